// File: rtl/cavlc_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cavlc_fifo_pkg
// Shared constants for the CAVLC code-word buffering stage.
//   DATA_W : word width of the storage block
//   ADDR_W : pointer width (depth = 2^ADDR_W)
//   DEPTH  : number of storage entries
//   LVL_W  : occupancy counter width (must hold 0..DEPTH inclusive)
// ---------------------------------------------------------------------------
package cavlc_fifo_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int LVL_W  = ADDR_W + 1;

   typedef logic [LVL_W-1:0] level_t;
endpackage : cavlc_fifo_pkg

// File: rtl/cavlc_fifo_ctrl_mem.sv
// ---------------------------------------------------------------------------
// FIFOMemory
// Storage block for the CAVLC buffer: 2^ADDR_W words of DATA_W bits, one
// synchronous write port and one combinational (show-ahead) read port.
// Ports:
//   Clk, nReset : clock, asynchronous active-low reset (zeroes all entries)
//   WrEn        : write strobe, stores WrData at WrAddr on the rising edge
//   WrAddr      : write address
//   WrData      : write data
//   OutEn       : output enable; RdData is forced to 0 when low
//   RdAddr      : read address
//   RdData      : entry at RdAddr (combinational)
// ---------------------------------------------------------------------------
module FIFOMemory
   import cavlc_fifo_pkg::*;
#(
   parameter int MEM_DATA_W = cavlc_fifo_pkg::DATA_W,
   parameter int MEM_ADDR_W = cavlc_fifo_pkg::ADDR_W
) (
   input  logic                  Clk,
   input  logic                  nReset,
   input  logic                  WrEn,
   input  logic [MEM_ADDR_W-1:0] WrAddr,
   input  logic [MEM_DATA_W-1:0] WrData,
   input  logic                  OutEn,
   input  logic [MEM_ADDR_W-1:0] RdAddr,
   output logic [MEM_DATA_W-1:0] RdData
);

   localparam int MEM_DEPTH = 1 << MEM_ADDR_W;

   logic [MEM_DATA_W-1:0] mem [MEM_DEPTH];

   // One register per entry so each can be cleared by the asynchronous reset.
   for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk or negedge nReset) begin
         if (!nReset) begin
            mem[gi] <= '0;
         end else if (WrEn && (WrAddr == MEM_ADDR_W'(gi))) begin
            mem[gi] <= WrData;
         end
      end
   end

   assign RdData = OutEn ? mem[RdAddr] : '0;

endmodule : FIFOMemory

// File: rtl/cavlc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// cavlc_fifo_ctrl
// Eight-entry buffer between the CAVLC code-word generator and the bitstream
// packer. Owns the pointers, occupancy count and status flags around the
// FIFOMemory storage block.
// Ports:
//   Clk, nReset        : clock, asynchronous active-low reset
//   WrValid/WrData     : producer side, word offered for enqueue
//   WrReady            : buffer can accept a word (not full)
//   RdValid/RdData     : consumer side, show-ahead head-of-queue word
//   RdReady            : consumer takes the head word
//   Flush              : synchronous clear of pointers/count (wins over push/pop)
//   Level              : occupancy 0..DEPTH
//   Full/Empty         : Level == DEPTH / Level == 0
//   AlmostFull         : Level >= AFULL_LEVEL
// ---------------------------------------------------------------------------
module cavlc_fifo_ctrl
   import cavlc_fifo_pkg::*;
#(
   parameter int DATA_W      = cavlc_fifo_pkg::DATA_W,
   parameter int ADDR_W      = cavlc_fifo_pkg::ADDR_W,
   parameter int AFULL_LEVEL = 6
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              WrValid,
   input  logic [DATA_W-1:0] WrData,
   output logic              WrReady,
   output logic              RdValid,
   output logic [DATA_W-1:0] RdData,
   input  logic              RdReady,
   input  logic              Flush,
   output logic [ADDR_W:0]   Level,
   output logic              Full,
   output logic              Empty,
   output logic              AlmostFull
);

   localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_LEVEL);
   localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   level_reg;
   logic [ADDR_W:0]   level_next;
   logic              full_reg;
   logic              empty_reg;
   logic              afull_reg;
   logic              push;
   logic              pop;
   logic              mem_we;

   // Handshakes are gated only by registered flags, so there is no
   // combinational path from WrValid/RdReady to any output.
   assign push   = WrValid & ~full_reg;
   assign pop    = RdReady & ~empty_reg;
   // A push offered in a flush cycle is discarded rather than written.
   assign mem_we = push & ~Flush;

   always_comb begin
      level_next = level_reg;
      unique case ({push, pop})
         2'b10:   level_next = level_reg + LVL_ONE;
         2'b01:   level_next = level_reg - LVL_ONE;
         default: level_next = level_reg;
      endcase
   end

   // Flags are decoded from the next count so they line up with the pointers.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         afull_reg  <= 1'b0;
      end else if (Flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         afull_reg  <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         level_reg <= level_next;
         full_reg  <= (level_next == FULL_LVL);
         empty_reg <= (level_next == '0);
         afull_reg <= (level_next >= AFULL_LVL);
      end
   end

   FIFOMemory #(
      .MEM_DATA_W (DATA_W),
      .MEM_ADDR_W (ADDR_W)
   ) u_mem (
      .Clk    (Clk),
      .nReset (nReset),
      .WrEn   (mem_we),
      .WrAddr (wr_ptr_reg),
      .WrData (WrData),
      .OutEn  (~empty_reg),
      .RdAddr (rd_ptr_reg),
      .RdData (RdData)
   );

   assign WrReady    = ~full_reg;
   assign RdValid    = ~empty_reg;
   assign Level      = level_reg;
   assign Full       = full_reg;
   assign Empty      = empty_reg;
   assign AlmostFull = afull_reg;

endmodule : cavlc_fifo_ctrl

// File: tb/tb_cavlc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cavlc_fifo_ctrl
// Table-driven vectors plus hand-written corner sequences. A queue holds the
// words the bench expects to be buffered; it is pushed when an accepted push
// is driven and popped when the consumer takes a word.
// ---------------------------------------------------------------------------
module tb_cavlc_fifo_ctrl;

   logic        Clk = 1'b0;
   logic        nReset = 1'b0;
   logic        WrValid = 1'b0;
   logic [15:0] WrData = '0;
   logic        WrReady;
   logic        RdValid;
   logic [15:0] RdData;
   logic        RdReady = 1'b0;
   logic        Flush = 1'b0;
   logic [3:0]  Level;
   logic        Full;
   logic        Empty;
   logic        AlmostFull;

   always #5 Clk = ~Clk;

   cavlc_fifo_ctrl #(
      .DATA_W      (16),
      .ADDR_W      (3),
      .AFULL_LEVEL (6)
   ) dut (
      .Clk        (Clk),
      .nReset     (nReset),
      .WrValid    (WrValid),
      .WrData     (WrData),
      .WrReady    (WrReady),
      .RdValid    (RdValid),
      .RdData     (RdData),
      .RdReady    (RdReady),
      .Flush      (Flush),
      .Level      (Level),
      .Full       (Full),
      .Empty      (Empty),
      .AlmostFull (AlmostFull)
   );

   typedef struct {
      logic        wv;
      logic [15:0] wd;
      logic        rr;
      logic        fl;
      logic [3:0]  lvl;   // expected Level after the edge
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Compare every output against the scoreboard state.
   task automatic check_outputs(input string tag);
      int lv;
      lv = sb_q.size();
      chk({tag, "_level"}, 32'(Level), 32'(lv));
      chk({tag, "_full"},  32'(Full),  32'(lv == 8));
      chk({tag, "_empty"}, 32'(Empty), 32'(lv == 0));
      chk({tag, "_afull"}, 32'(AlmostFull), 32'(lv >= 6));
      chk({tag, "_wrready"}, 32'(WrReady), 32'(lv != 8));
      chk({tag, "_rdvalid"}, 32'(RdValid), 32'(lv != 0));
      if (lv != 0) chk({tag, "_rddata"}, 32'(RdData), 32'(sb_q[0]));
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input logic wv, input logic [15:0] wd, input logic rr, input logic fl);
      bit do_push;
      bit do_pop;
      WrValid = wv;
      WrData  = wd;
      RdReady = rr;
      Flush   = fl;
      @(negedge Clk);
      check_outputs("pre");
      do_push = wv && (sb_q.size() < 8);
      do_pop  = rr && (sb_q.size() > 0);
      $display("txn wv=%0d wd=0x%04h rr=%0d fl=%0d level=%0d rddata=0x%04h", wv, wd, rr, fl, Level, RdData);
      @(posedge Clk);
      if (fl) begin
         sb_q.delete();
      end else begin
         if (do_pop)  void'(sb_q.pop_front());
         if (do_push) sb_q.push_back(wd);
      end
      #1;
      WrValid = 1'b0;
      RdReady = 1'b0;
      Flush   = 1'b0;
   endtask

   // Reset pulsed between edges; outputs must clear immediately.
   task automatic mid_reset(input string tag);
      #2 nReset = 1'b0;
      #1;
      sb_q.delete();
      chk({tag, "_level"},   32'(Level),   32'd0);
      chk({tag, "_empty"},   32'(Empty),   32'd1);
      chk({tag, "_rdvalid"}, 32'(RdValid), 32'd0);
      chk({tag, "_wrready"}, 32'(WrReady), 32'd1);
      chk({tag, "_full"},    32'(Full),    32'd0);
      chk({tag, "_afull"},   32'(AlmostFull), 32'd0);
      chk({tag, "_rddata"},  32'(RdData),  32'd0);
      $display("txn async reset %s level=%0d empty=%0d", tag, Level, Empty);
      #2 nReset = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Fill 0x1001..0x1008, overflow attempts, drain in order.
      for (int i = 0; i < 8; i++)
         tbl.push_back('{wv: 1'b1, wd: 16'(16'h1001 + i), rr: 1'b0, fl: 1'b0, lvl: 4'(i + 1)});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{wv: 1'b1, wd: 16'hDEAD, rr: 1'b0, fl: 1'b0, lvl: 4'd8});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{wv: 1'b0, wd: 16'h0000, rr: 1'b1, fl: 1'b0, lvl: 4'(7 - i)});
      // Preload 4, then 20 cycles of concurrent push/pop across the wrap.
      for (int i = 0; i < 4; i++)
         tbl.push_back('{wv: 1'b1, wd: 16'(16'h2000 + i), rr: 1'b0, fl: 1'b0, lvl: 4'(i + 1)});
      for (int i = 0; i < 20; i++)
         tbl.push_back('{wv: 1'b1, wd: 16'(16'h2004 + i), rr: 1'b1, fl: 1'b0, lvl: 4'd4});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{wv: 1'b0, wd: 16'h0000, rr: 1'b1, fl: 1'b0, lvl: 4'(3 - i)});

      // Power-on reset state.
      @(posedge Clk);
      #1;
      check_outputs("reset");
      chk("reset_rddata", 32'(RdData), 32'd0);
      nReset = 1'b1;
      @(posedge Clk);
      #1;

      // Asynchronous reset mid-cycle with data present, then idle.
      step(1'b1, 16'h0A0A, 1'b0, 1'b0);
      step(1'b1, 16'h0B0B, 1'b0, 1'b0);
      mid_reset("rst_mid");
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);

      // Table-driven section.
      foreach (tbl[i]) begin
         step(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
         chk("tbl_level", 32'(Level), 32'(tbl[i].lvl));
      end
      check_outputs("after_tbl");

      // Empty boundary: push and pop offered at level 0 -> push only.
      step(1'b1, 16'h3001, 1'b1, 1'b0);
      chk("empty_bnd_level", 32'(Level), 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Full boundary: push and pop offered at level 8 -> pop only.
      for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h4001 + i), 1'b0, 1'b0);
      step(1'b1, 16'hBEEF, 1'b1, 1'b0);
      chk("full_bnd_level", 32'(Level), 32'd7);
      for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
      check_outputs("full_bnd_drained");

      // Flush with a concurrent push at level 5.
      for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h5001 + i), 1'b0, 1'b0);
      step(1'b1, 16'hBAD1, 1'b0, 1'b1);
      chk("flush_level", 32'(Level), 32'd0);
      chk("flush_empty", 32'(Empty), 32'd1);
      step(1'b1, 16'h5555, 1'b0, 1'b0);
      chk("flush_head", 32'(RdData), 32'h5555);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check_outputs("flush_drained");

      // Asynchronous reset at level 5.
      for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h6001 + i), 1'b0, 1'b0);
      mid_reset("rst_lvl5");
      step(1'b1, 16'h6666, 1'b0, 1'b0);
      chk("rst_head", 32'(RdData), 32'h6666);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check_outputs("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cavlc_fifo_ctrl
